dbglog_arb: RTL
===============

Name: dbglog_arb

Overview:
- Round-robin scheduler that shares the single debug-log UART printer (dbglog) among NREQ requester blocks.
- Each requester offers a snapshot: a 40-bit ASCII tag plus six 32-bit values. dbglog prints only bits [17:0] of each value, in octal.
- The arbiter latches the winning snapshot and holds it stable while dbglog samples it, then drives dbglog's `we` handshake. It blocks further grants until the UART line has drained.
- Sits between the debug-instrumented blocks and dbglog. It shares clk and reset_n with dbglog.

Parameters:
- NREQ, 4: number of requesters. The design is fixed at 4; the parameter exists for checking only.
- CLK_FRQ, 27_000_000: clk frequency in Hz. Must match dbglog.
- BAUD_RATE, 115_200: UART baud rate. Must match dbglog.
- HOLD_CYC, 64: cycles `we` stays high. Must be ≥ 56, which covers dbglog's 55-cycle buffer fill.
- MSG_CHARS, 54: characters per log line, including CR and LF.
- GAP_MARGIN, 1024: extra cycles of slack after the computed print time.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  NREQ  per-requester request, level-sensitive.
- tag_in  in  NREQ*40  per-requester tag. Requester i uses [i*40+:40].
- val_in  in  NREQ*192  per-requester values. Requester i uses [i*192+:192]; value k sits at offset k*32.
- log_en  in  1  1 = print; 0 = discard requests.
- ack  out  NREQ  one-cycle pulse: snapshot consumed.
- regw  out  40  tag to dbglog.
- reg0..reg5  out  32 each  values to dbglog.
- we  out  1  write strobe to dbglog.
- grant_id  out  2  index of the last granted requester.
- busy  out  1  high whenever the state is not IDLE.
- drop_cnt  out  16  saturating count of discarded requests.

Behaviour:
- Reset values: all outputs 0, state IDLE, round-robin pointer 0, counter 0.
- Derived constant: GAP_CYC = MSG_CHARS*10*(CLK_FRQ/BAUD_RATE) + GAP_MARGIN. Integer division. The counter is 24 bits; elaboration fails if GAP_CYC ≥ 2^24.
- Arbitration:
  - Winner = first set req bit searching from ptr upward, mod 4.
  - After any ack, ptr = winner+1 mod 4.
- IDLE, log_en=1, any req set. On the next edge:
  - latch tag_in/val_in of the winner into regw/reg0..5;
  - ack[winner]=1 for exactly one cycle;
  - we=1, grant_id=winner;
  - load counter = HOLD_CYC-1; go to HOLD.
- IDLE, log_en=0, any req set. On the next edge:
  - ack[winner]=1 for one cycle; ptr advances;
  - drop_cnt += 1, saturating at 16'hFFFF;
  - regw/reg* and we are unchanged; stay IDLE.
- HOLD:
  - we=1; regw/reg* are frozen; counter decrements.
  - When counter = 0: we=0, load counter = GAP_CYC-1, go to GAP.
  - `we` is therefore high for exactly HOLD_CYC cycles.
- GAP:
  - we=0; outputs stay frozen; counter decrements.
  - When counter = 0: go to IDLE.
  - Requests arriving during HOLD or GAP stay pending. They are not acked and not dropped.
- Back-to-back: the first grant from IDLE happens the cycle after IDLE is entered. Minimum grant spacing is 1 + HOLD_CYC + GAP_CYC cycles.
- Requester contract: req must fall in the cycle after ack. If req is still high, it is a new request. The snapshot must be valid whenever req is high.
- Simultaneous requests: the round-robin pointer decides. Only one ack per cycle, ever.
- log_en falling during HOLD or GAP: the transaction completes normally. dbglog cannot be aborted.
- log_en rising: it takes effect at the next IDLE decision.
- Reset mid-operation: everything returns to reset values at once; no ack is issued. dbglog is reset by the same reset_n, so there is no stale handshake.
- A req bit changing during HOLD or GAP has no effect until IDLE.

Decomposition:
- Package dbglog_arb_pkg holds:
  - state encoding: IDLE, HOLD, GAP;
  - field widths: TAG_W=40, VAL_W=32, NVAL=6;
  - the GAP_CYC function.
- Sub-module rr_pick4: combinational pick of the first set bit from ptr. Outputs are a valid flag and a 2-bit index. The pointer register stays in dbglog_arb.

Test Plan:
Sim parameters: CLK_FRQ=1_152_000, BAUD_RATE=115_200 (10 cycles per bit), GAP_MARGIN=16, so GAP_CYC=5416.
- Single request: req=4'b0100 with tag "ABCDE" and val k = k+1.
  - Next cycle: ack=4'b0100, we=1, grant_id=2, regw="ABCDE", reg3=4.
  - we stays high exactly 64 cycles; busy stays high 64+5416 cycles.
- Round-robin: req=4'b1111 held, each bit dropped after its ack.
  - Grant order is 0,1,2,3.
  - Grants are spaced exactly 1+64+5416 cycles apart.
- Pending during GAP: req[1] rises mid-GAP.
  - No ack until IDLE.
  - Granted on the first IDLE cycle plus one.
- Discard: log_en=0, req=4'b0011 (each bit dropped after its ack).
  - Two acks in consecutive cycles: bit 0 first, then bit 1.
  - drop_cnt=2; we never rises; regw unchanged.
- Saturation and mid-transaction log_en: drive 70000 discarded requests → drop_cnt=16'hFFFF.
  - Separately, drop log_en during HOLD: we still completes 64 cycles and GAP completes.
- Reset in HOLD: reset_n low at HOLD cycle 10.
  - Immediately we=0, ack=0, busy=0, drop_cnt=0.
  - After release, req=4'b0001 is granted with grant_id=0.

Source files
------------

// File: rtl/dbglog_arb_pkg.sv
// rtl/dbglog_arb_pkg.sv - shared types, field widths and print-gap helper for dbglog_arb
package dbglog_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam int TAG_W = 40;
    localparam int VAL_W = 32;
    localparam int NVAL  = 6;
    localparam int CNT_W = 24;

    // Cycles needed for one full log line to leave the UART, plus slack.
    function automatic int gap_cyc(input int msg_chars, input int clk_frq,
                                   input int baud_rate, input int gap_margin);
        return msg_chars * 10 * (clk_frq / baud_rate) + gap_margin;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// rtl/rr_pick4.sv - combinational round-robin pick of the first set request at or after ptr
module rr_pick4 (
    input  logic [3:0] i_req,
    input  logic [1:0] i_ptr,
    output logic       o_valid,
    output logic [1:0] o_idx
);

    assign o_valid = |i_req;

    // Walk downward so the closest set bit after the pointer wins.
    always_comb begin
        o_idx = i_ptr;
        for (int j = 3; j >= 0; j--) begin
            if (i_req[i_ptr + 2'(j)]) begin
                o_idx = i_ptr + 2'(j);
            end
        end
    end

endmodule

// File: rtl/dbglog_arb.sv
// rtl/dbglog_arb.sv - round-robin arbiter sharing the dbglog UART printer among four requesters
module dbglog_arb
    import dbglog_arb_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int CLK_FRQ    = 27_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int HOLD_CYC   = 64,
    parameter int MSG_CHARS  = 54,
    parameter int GAP_MARGIN = 1024
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [NREQ-1:0]              req,
    input  logic [NREQ*TAG_W-1:0]        tag_in,
    input  logic [NREQ*VAL_W*NVAL-1:0]   val_in,
    input  logic                         log_en,
    output logic [NREQ-1:0]              ack,
    output logic [TAG_W-1:0]             regw,
    output logic [VAL_W-1:0]             reg0,
    output logic [VAL_W-1:0]             reg1,
    output logic [VAL_W-1:0]             reg2,
    output logic [VAL_W-1:0]             reg3,
    output logic [VAL_W-1:0]             reg4,
    output logic [VAL_W-1:0]             reg5,
    output logic                         we,
    output logic [1:0]                   grant_id,
    output logic                         busy,
    output logic [15:0]                  drop_cnt
);

    localparam int GAP_CYC = gap_cyc(MSG_CHARS, CLK_FRQ, BAUD_RATE, GAP_MARGIN);
    localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP_CYC - 1);

    if (NREQ != 4) begin : g_bad_nreq
        $error("dbglog_arb supports exactly 4 requesters");
    end
    if (HOLD_CYC < 56) begin : g_bad_hold
        $error("HOLD_CYC too short for dbglog buffer fill");
    end
    if (GAP_CYC >= (1 << CNT_W)) begin : g_bad_gap
        $error("GAP_CYC does not fit the 24-bit counter");
    end

    state_t             r_state;
    logic [1:0]         r_ptr;
    logic [CNT_W-1:0]   r_cnt;
    logic               w_valid;
    logic [1:0]         w_idx;
    logic [TAG_W-1:0]   w_tag;
    logic [VAL_W*NVAL-1:0] w_vals;

    rr_pick4 u_pick (
        .i_req   (req),
        .i_ptr   (r_ptr),
        .o_valid (w_valid),
        .o_idx   (w_idx)
    );

    assign w_tag  = tag_in[w_idx*TAG_W +: TAG_W];
    assign w_vals = val_in[w_idx*(VAL_W*NVAL) +: VAL_W*NVAL];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_ptr    <= '0;
            r_cnt    <= '0;
            ack      <= '0;
            regw     <= '0;
            reg0     <= '0;
            reg1     <= '0;
            reg2     <= '0;
            reg3     <= '0;
            reg4     <= '0;
            reg5     <= '0;
            we       <= 1'b0;
            grant_id <= '0;
            busy     <= 1'b0;
            drop_cnt <= '0;
        end else begin
            ack <= '0;
            case (r_state)
                IDLE: begin
                    if (w_valid) begin
                        ack[w_idx] <= 1'b1;
                        r_ptr      <= w_idx + 2'd1;
                        if (log_en) begin
                            regw     <= w_tag;
                            reg0     <= w_vals[0*VAL_W +: VAL_W];
                            reg1     <= w_vals[1*VAL_W +: VAL_W];
                            reg2     <= w_vals[2*VAL_W +: VAL_W];
                            reg3     <= w_vals[3*VAL_W +: VAL_W];
                            reg4     <= w_vals[4*VAL_W +: VAL_W];
                            reg5     <= w_vals[5*VAL_W +: VAL_W];
                            we       <= 1'b1;
                            grant_id <= w_idx;
                            r_cnt    <= HOLD_LD;
                            r_state  <= HOLD;
                            busy     <= 1'b1;
                        end else if (drop_cnt != 16'hFFFF) begin
                            drop_cnt <= drop_cnt + 16'd1;
                        end
                    end
                end
                HOLD: begin
                    if (r_cnt == '0) begin
                        we      <= 1'b0;
                        r_cnt   <= GAP_LD;
                        r_state <= GAP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                GAP: begin
                    // Snapshot stays frozen while the UART drains the line.
                    if (r_cnt == '0) begin
                        r_state <= IDLE;
                        busy    <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    we      <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
